// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared definitions for the dynamic branch predictor: mode
//               encodings, saturating counter step and PHT reset value.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // Prediction mode encodings
    localparam int BP_NT      = 0;
    localparam int BP_T       = 1;
    localparam int BP_BIMODAL = 2;
    localparam int BP_GSHARE  = 3;

    // Widest counter the helpers support
    localparam int C_CNT_MAX_W = 4;

    // One saturating step of a WIDTH-bit counter (WIDTH <= 4): up or down,
    // clamped at 0 and at 2^WIDTH-1.
    function automatic logic [C_CNT_MAX_W-1:0] sat_step(
        input logic [C_CNT_MAX_W-1:0] cnt,
        input logic                   up,
        input int                     width
    );
        logic [C_CNT_MAX_W:0] top;
        top = (5'd1 << width) - 5'd1;
        if (up) begin
            sat_step = (cnt == top[C_CNT_MAX_W-1:0]) ? cnt : cnt + 4'd1;
        end else begin
            sat_step = (cnt == 4'd0) ? cnt : cnt - 4'd1;
        end
    endfunction

    // Weakly not-taken: 2^(WIDTH-1)-1
    function automatic logic [C_CNT_MAX_W-1:0] pht_reset_value(input int width);
        logic [C_CNT_MAX_W:0] v;
        v = (5'd1 << (width - 1)) - 5'd1;
        return v[C_CNT_MAX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : N-bit up/down counter with enable that saturates at zero and
//               at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_up,
    output logic [N-1:0] o_count
);

    logic [N-1:0] r_count;

    // Count on enable, holding at either end of the range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            if (i_up && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end else if (!i_up && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Dynamic branch predictor for the ID stage. Static not-taken,
//               static taken, bimodal or gshare selected by MODE. Lookup is a
//               combinational read of the registered PHT/GHR; resolution from
//               EX trains the PHT, shifts the GHR and updates statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int MODE    = 2,
    parameter int GHR_W   = 4,
    parameter int STAT_W  = 16,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lookup_valid_i,
    input  logic [31:0]       lookup_pc_i,
    output logic              predict_taken_o,
    output logic [IDX_W-1:0]  lookup_idx_o,
    input  logic              update_valid_i,
    input  logic [IDX_W-1:0]  update_idx_i,
    input  logic              update_taken_i,
    input  logic              update_pred_i,
    output logic              mispredict_o,
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] miss_cnt_o
);

    logic [IDX_W-1:0] w_pc_idx;
    logic             w_unused;

    // Word-aligned PC bits select the table entry
    assign w_pc_idx     = lookup_pc_i[IDX_W+1:2];
    assign mispredict_o = update_valid_i & (update_taken_i ^ update_pred_i);

    // PC bits outside the index never influence the prediction
    assign w_unused = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0], update_idx_i};

    generate
        if (MODE == BP_BIMODAL || MODE == BP_GSHARE) begin : g_pht
            logic [CNT_W-1:0] r_pht [ENTRIES];
            logic [IDX_W-1:0] w_idx;
            logic [CNT_W-1:0] w_next_cnt;

            if (MODE == BP_GSHARE) begin : g_ghr
                logic [GHR_W-1:0] r_ghr;
                logic [GHR_W-1:0] w_ghr_next;

                if (GHR_W == 1) begin : g_ghr_one
                    assign w_ghr_next = update_taken_i;
                end else begin : g_ghr_shift
                    assign w_ghr_next = {r_ghr[GHR_W-2:0], update_taken_i};
                end

                // History is non-speculative: it shifts only at resolution
                always_ff @(posedge clk_i or negedge rst_i) begin
                    if (!rst_i) begin
                        r_ghr <= '0;
                    end else if (update_valid_i) begin
                        r_ghr <= w_ghr_next;
                    end
                end

                // History folds into the low index bits
                assign w_idx = w_pc_idx ^ IDX_W'(r_ghr);
            end else begin : g_no_ghr
                assign w_idx = w_pc_idx;
            end

            assign w_next_cnt = CNT_W'(sat_step(4'(r_pht[update_idx_i]), update_taken_i, CNT_W));

            // Train the resolved entry; no bypass to a same-cycle lookup
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    for (int i = 0; i < ENTRIES; i++) begin
                        r_pht[i] <= CNT_W'(pht_reset_value(CNT_W));
                    end
                end else if (update_valid_i) begin
                    r_pht[update_idx_i] <= w_next_cnt;
                end
            end

            assign lookup_idx_o    = w_idx;
            assign predict_taken_o = lookup_valid_i & r_pht[w_idx][CNT_W-1];
        end else begin : g_static
            assign lookup_idx_o    = w_pc_idx;
            assign predict_taken_o = lookup_valid_i & (MODE == BP_T);
        end
    endgenerate

    sat_counter #(
        .N (STAT_W)
    ) u_branch_cnt (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .i_en    (update_valid_i),
        .i_up    (1'b1),
        .o_count (branch_cnt_o)
    );

    sat_counter #(
        .N (STAT_W)
    ) u_miss_cnt (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .i_en    (mispredict_o),
        .i_up    (1'b1),
        .o_count (miss_cnt_o)
    );

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage RV32 pipeline. It replaces the fixed predict-not-taken behaviour, where a branch resolves in ID and a taken branch flushes IF/ID. It sits beside the IF/ID register:
- **Lookup** is done for the instruction in ID. The ID-stage branch adder already supplies the target, so no BTB is needed.
- **Resolution** comes back from EX, which lets the comparator move out of the ID critical path.
- **Modes:** static not-taken, static taken, bimodal, or gshare, selected by parameter.
- **Outputs:** a misprediction flush/redirect signal and performance counters.

## Interface
Parameters:
- `ENTRIES`, 16: pattern history table depth; power of two, 2..1024.
- `CNT_W`, 2: saturating counter width, 1..4.
- `MODE`, 2: 0 = always not-taken, 1 = always taken, 2 = bimodal, 3 = gshare.
- `GHR_W`, 4: global history length; used only in MODE 3, and must be ≤ log2(`ENTRIES`).
- `STAT_W`, 16: width of the performance counters.

Ports (`IDX_W` = log2(`ENTRIES`)):
- `clk_i`  in  1  clock; everything is posedge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `lookup_valid_i`  in  1  the ID instruction is a conditional branch.
- `lookup_pc_i`  in  32  PC of the ID instruction.
- `predict_taken_o`  out  1  prediction (combinational); 0 when `lookup_valid_i`=0.
- `lookup_idx_o`  out  `IDX_W`  table index used; carried down ID/EX with the branch.
- `update_valid_i`  in  1  a branch resolves in EX this cycle.
- `update_idx_i`  in  `IDX_W`  `lookup_idx_o` value returned from ID/EX.
- `update_taken_i`  in  1  actual outcome.
- `update_pred_i`  in  1  the prediction made for this branch.
- `mispredict_o`  out  1  combinational: `update_valid_i` & (`update_taken_i` ≠ `update_pred_i`).
- `branch_cnt_o`  out  `STAT_W`  number of resolved branches.
- `miss_cnt_o`  out  `STAT_W`  number of mispredictions.

## Operation
Index computation:
- MODE 2: index = `lookup_pc_i`[`IDX_W`+1:2].
- MODE 3: the same PC bits, with the low `GHR_W` bits XORed with the GHR.

Prediction:
- MODE 2/3: prediction = MSB of PHT[index].
- MODE 0/1: prediction is constant 0/1. The PHT and GHR are not instantiated, and `lookup_idx_o` = PC index.

Update, when `update_valid_i`=1:
- PHT[`update_idx_i`] increments if taken, decrements if not.
- The counter saturates at 2^`CNT_W`−1 and at 0; it never wraps.
- GHR = {GHR[`GHR_W`−2:0], `update_taken_i`}. The GHR is non-speculative: it changes only at resolution.

Statistics, when `update_valid_i`=1:
- `branch_cnt_o` increments.
- `miss_cnt_o` increments when `mispredict_o` is also 1.
- Both counters saturate at all-ones.

Flush duty is the CPU's: `mispredict_o` flushes IF/ID and ID/EX and redirects the PC. Any in-flight branch killed by the flush must present `update_valid_i`=0.

## Timing
- **Reset (asynchronous, `rst_i`=0):** every PHT entry = 2^(`CNT_W`−1)−1 (weakly not-taken; 1 for `CNT_W`=2), GHR = 0, both stat counters = 0.
- **Outputs during reset:** `predict_taken_o`=0 in MODE 0/2/3 and 1 in MODE 1; `mispredict_o` follows its inputs.
- **Lookup latency:** 0 cycles; combinational read of the registered PHT/GHR.
- **Update latency:** 1 cycle. A write takes effect at the clock edge and is first visible to a lookup in the following cycle.
- **Same-cycle update and lookup to the same index:** the lookup returns the pre-update value; there is no bypass.
- **GHR:** a lookup in the same cycle as an update uses the pre-shift GHR.
- **Reset mid-operation:** all state returns to reset values immediately; pending updates are discarded.
- No stall input. Holding `lookup_pc_i` constant holds the prediction, so it is stall-safe.

## Structure
- The shared package `bp_pkg` holds:
  - the MODE encodings (`BP_NT`, `BP_T`, `BP_BIMODAL`, `BP_GSHARE`);
  - a `CNT_W`-parametrised saturating increment/decrement function;
  - the reset-value constant.
- One sub-module, `sat_counter`: an `N`-bit saturating up/down counter with enable. It is used for the stat counters.
- The PHT is a flop array, not a RAM, because it needs asynchronous reset and a combinational read.
- The GHR is inline, generated only when MODE=3.

## Test plan
1. **Reset values.** Default parameters, reset; `lookup_pc_i`=0x40 → `predict_taken_o`=0, `lookup_idx_o`=0, both counters 0.
2. **Bimodal training and saturation.** Three taken updates to idx 0x0 → counter 1→2→3→3; lookup of 0x40 predicts 1 from the first update onward. Then two not-taken updates → counter 1, prediction 0.
3. **Misprediction flag and stats.** Ten updates with `update_pred_i`=0, of which 4 have `update_taken_i`=1 → `mispredict_o` high on exactly those 4 cycles; end state `branch_cnt_o`=10, `miss_cnt_o`=4. With `STAT_W`=3, nine updates → `branch_cnt_o` holds at 7.
4. **Same-index collision.** Counter at 1, taken update to idx 5 plus a lookup of PC 0x14 (idx 5) in the same cycle → prediction 0 in that cycle, 1 in the next cycle.
5. **Gshare history.** MODE 3, `GHR_W`=4; after updates taken, taken, not-taken, taken → GHR = 4'b1101, and lookup of PC 0x0 gives `lookup_idx_o` = 0xD.
6. **Static modes and reset mid-training.**
   - MODE 1 → `predict_taken_o`=1 for any PC, including during reset.
   - MODE 2, train idx 3 to 3, then assert `rst_i` mid-cycle → prediction drops to 0 immediately, with no clock edge.
